wb_qspi_arbiter: RTL and testbench

Two-master Wishbone arbiter and address decoder in front of the shared QSPI memory adapter. The requesters are the instruction bus (read-only) and the data bus (read/write).
- Decodes each byte address to ROM, RAM or unmapped.
- Grants one requester at a time and drives ROM/RAM select, word address, byte enables and write data into the adapter as registered, stable values.
- Routes the adapter's ack and read data back to the granted master.
- Blocks data-bus writes to ROM and accesses to unmapped space with an error ack. The adapter never sees these, so it cannot turn a ROM write into a stray RAM write.

---
 rtl/wb_qspi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_qspi_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_qspi_arbiter.sv
// Two-master Wishbone arbiter/decoder in front of the QSPI memory adapter.
// All mem_* outputs are registered and held stable for the life of a grant.
module wb_qspi_arbiter #(
   parameter logic [7:0] ROM_PREFIX  = 8'h00,
   parameter logic [7:0] RAM_PREFIX  = 8'h01,
   parameter bit         ROUND_ROBIN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic        ibus_stb_i,
   input  logic [31:0] ibus_adr_i,
   output logic        ibus_ack_o,
   output logic        ibus_err_o,
   output logic [31:0] ibus_dat_o,
   input  logic        dbus_stb_i,
   input  logic        dbus_we_i,
   input  logic [3:0]  dbus_be_i,
   input  logic [31:0] dbus_adr_i,
   input  logic [31:0] dbus_dat_i,
   output logic        dbus_ack_o,
   output logic        dbus_err_o,
   output logic [31:0] dbus_dat_o,
   output logic        mem_sel_rom_ram_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [21:0] mem_adr_o,
   output logic [31:0] mem_dat_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_dat_i
);

   // state  | meaning
   // IDLE   | no grant, choosing a winner
   // BUSY_I | ibus transaction at the adapter
   // BUSY_D | dbus transaction at the adapter
   // ERR_I  | one-cycle error ack to ibus
   // ERR_D  | one-cycle error ack to dbus
   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, ERR_I, ERR_D} state_e;

   state_e      state_q, state_d;
   logic        last_d_q, last_d_d;   // 1 = last grant went to dbus
   logic        sel_q, sel_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [21:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;

   logic i_rom, i_ram, d_rom, d_ram;
   logic i_illegal, d_illegal;
   logic pick_d, pick_i;

   logic unused_adr_lsbs;
   assign unused_adr_lsbs = ^{ibus_adr_i[1:0], dbus_adr_i[1:0]};

   always_comb begin
      i_rom     = (ibus_adr_i[31:24] == ROM_PREFIX);
      i_ram     = (ibus_adr_i[31:24] == RAM_PREFIX);
      d_rom     = (dbus_adr_i[31:24] == ROM_PREFIX);
      d_ram     = (dbus_adr_i[31:24] == RAM_PREFIX);
      i_illegal = !(i_rom || i_ram);
      d_illegal = !(d_rom || d_ram) || (dbus_we_i && d_rom);
      // On contention with round robin, dbus wins only if ibus had the last grant.
      pick_d    = dbus_stb_i && (!ibus_stb_i || !ROUND_ROBIN || !last_d_q);
      pick_i    = ibus_stb_i && !pick_d;
   end

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      sel_d      = sel_q;
      stb_d      = stb_q;
      we_d       = we_q;
      be_d       = be_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      ibus_ack_o = 1'b0;
      ibus_err_o = 1'b0;
      ibus_dat_o = '0;
      dbus_ack_o = 1'b0;
      dbus_err_o = 1'b0;
      dbus_dat_o = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_d) begin
               last_d_d = 1'b1;
               if (d_illegal) begin
                  state_d = ERR_D;
               end else begin
                  state_d = BUSY_D;
                  stb_d   = 1'b1;
                  sel_d   = d_ram;
                  adr_d   = dbus_adr_i[23:2];
                  we_d    = dbus_we_i;
                  be_d    = dbus_be_i;
                  dat_d   = dbus_dat_i;
               end
            end else if (pick_i) begin
               last_d_d = 1'b0;
               if (i_illegal) begin
                  state_d = ERR_I;
               end else begin
                  state_d = BUSY_I;
                  stb_d   = 1'b1;
                  sel_d   = i_ram;
                  adr_d   = ibus_adr_i[23:2];
                  we_d    = 1'b0;
                  be_d    = 4'b1111;
                  dat_d   = '0;
               end
            end
         end
         BUSY_I: begin
            // A master that dropped stb early still lets the access finish; its ack is swallowed.
            ibus_ack_o = mem_ack_i && ibus_stb_i;
            ibus_dat_o = mem_dat_i;
            if (mem_ack_i) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end
         end
         BUSY_D: begin
            dbus_ack_o = mem_ack_i && dbus_stb_i;
            dbus_dat_o = mem_dat_i;
            if (mem_ack_i) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end
         end
         ERR_I: begin
            ibus_ack_o = 1'b1;
            ibus_err_o = 1'b1;
            state_d    = IDLE;
         end
         ERR_D: begin
            dbus_ack_o = 1'b1;
            dbus_err_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         sel_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         sel_q    <= sel_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         be_q     <= be_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
      end
   end

   assign mem_sel_rom_ram_o = sel_q;
   assign mem_stb_o         = stb_q;
   assign mem_we_o          = we_q;
   assign mem_be_o          = be_q;
   assign mem_adr_o         = adr_q;
   assign mem_dat_o         = dat_q;

endmodule

// File: tb/tb_wb_qspi_arbiter.sv
// Directed bench for wb_qspi_arbiter: scoreboard of expected adapter requests,
// a latency-programmable adapter responder, and a fixed-priority second instance.
module tb_wb_qspi_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_in = 1'b1;
   logic        ibus_stb_i = 1'b0;
   logic [31:0] ibus_adr_i = '0;
   logic        ibus_ack_o, ibus_err_o;
   logic [31:0] ibus_dat_o;
   logic        dbus_stb_i = 1'b0;
   logic        dbus_we_i = 1'b0;
   logic [3:0]  dbus_be_i = '0;
   logic [31:0] dbus_adr_i = '0;
   logic [31:0] dbus_dat_i = '0;
   logic        dbus_ack_o, dbus_err_o;
   logic [31:0] dbus_dat_o;
   logic        mem_sel_rom_ram_o, mem_stb_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [21:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_dat_i = '0;

   logic        fp_ibus_stb = 1'b0, fp_dbus_stb = 1'b0;
   logic        fp_ibus_ack, fp_ibus_err, fp_dbus_ack, fp_dbus_err;
   logic [31:0] fp_ibus_dat, fp_dbus_dat;
   logic        fp_mem_sel, fp_mem_stb, fp_mem_we;
   logic [3:0]  fp_mem_be;
   logic [21:0] fp_mem_adr;
   logic [31:0] unused_fp_mem_dat;
   logic        fp_mem_ack = 1'b0;
   logic [31:0] fp_mem_rdat = 32'h5A5A_0001;

   always #5 clk_i = ~clk_i;

   wb_qspi_arbiter #(.ROUND_ROBIN(1'b1)) dut (
      .clk_i(clk_i), .rst_in(rst_in),
      .ibus_stb_i(ibus_stb_i), .ibus_adr_i(ibus_adr_i), .ibus_ack_o(ibus_ack_o),
      .ibus_err_o(ibus_err_o), .ibus_dat_o(ibus_dat_o),
      .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i),
      .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i), .dbus_ack_o(dbus_ack_o),
      .dbus_err_o(dbus_err_o), .dbus_dat_o(dbus_dat_o),
      .mem_sel_rom_ram_o(mem_sel_rom_ram_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
      .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i));

   wb_qspi_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk_i(clk_i), .rst_in(rst_in),
      .ibus_stb_i(fp_ibus_stb), .ibus_adr_i(ibus_adr_i), .ibus_ack_o(fp_ibus_ack),
      .ibus_err_o(fp_ibus_err), .ibus_dat_o(fp_ibus_dat),
      .dbus_stb_i(fp_dbus_stb), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i),
      .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i), .dbus_ack_o(fp_dbus_ack),
      .dbus_err_o(fp_dbus_err), .dbus_dat_o(fp_dbus_dat),
      .mem_sel_rom_ram_o(fp_mem_sel), .mem_stb_o(fp_mem_stb), .mem_we_o(fp_mem_we),
      .mem_be_o(fp_mem_be), .mem_adr_o(fp_mem_adr), .mem_dat_o(unused_fp_mem_dat),
      .mem_ack_i(fp_mem_ack), .mem_dat_i(fp_mem_rdat));

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        sel;
      logic [21:0] adr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] dat;
      bit          chk_dat;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   bit   have_cur = 0;
   logic stb_prev = 1'b0;

   // Scoreboard: each rising mem_stb_o must match the next expected request,
   // and the fields must stay put for as long as the strobe is high.
   always @(negedge clk_i) begin
      if (!rst_in) begin
         stb_prev = 1'b0;
         have_cur = 0;
      end else begin
         if (mem_stb_o && !stb_prev) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_mem_stb", 32'd1, 32'd0);
               have_cur = 0;
            end else begin
               cur = sb_q.pop_front();
               have_cur = 1;
            end
         end
         if (mem_stb_o && have_cur) begin
            chk("sb_sel", mem_sel_rom_ram_o, cur.sel);
            chk("sb_adr", mem_adr_o, cur.adr);
            chk("sb_we", mem_we_o, cur.we);
            chk("sb_be", mem_be_o, cur.be);
            if (cur.chk_dat) chk("sb_dat", mem_dat_o, cur.dat);
         end
         stb_prev = mem_stb_o;
      end
   end

   int lat = 2;
   int rcnt = 0;
   logic [31:0] rsp_dat = '0;
   int fp_cnt = 0;

   always @(posedge clk_i) begin
      #1;
      if (!rst_in) begin
         rcnt = 0; mem_ack_i = 1'b0;
      end else if (mem_ack_i) begin
         mem_ack_i = 1'b0; rcnt = 0;
      end else if (mem_stb_o) begin
         rcnt++;
         if (rcnt >= lat) begin
            mem_ack_i = 1'b1;
            mem_dat_i = rsp_dat;
         end
      end
   end

   always @(posedge clk_i) begin
      #1;
      if (!rst_in) begin
         fp_cnt = 0; fp_mem_ack = 1'b0;
      end else if (fp_mem_ack) begin
         fp_mem_ack = 1'b0; fp_cnt = 0;
      end else if (fp_mem_stb) begin
         fp_cnt++;
         if (fp_cnt >= 2) fp_mem_ack = 1'b1;
      end
   end

   function automatic bit ack_hit(input int which);
      case (which)
         0: return ibus_ack_o;
         1: return dbus_ack_o;
         2: return ibus_ack_o || dbus_ack_o;
         default: return fp_ibus_ack || fp_dbus_ack;
      endcase
   endfunction

   task automatic wait_ack(input int which, input int max, output int n);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!ack_hit(which) && n < max);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic exp_t mk(input logic sel, input logic [21:0] adr, input logic we,
                               input logic [3:0] be, input logic [31:0] dat, input bit cd);
      exp_t e;
      e.sel = sel; e.adr = adr; e.we = we; e.be = be; e.dat = dat; e.chk_dat = cd;
      return e;
   endfunction

   int n;

   initial begin
      // reset state
      #1 rst_in = 1'b0;
      #2;
      chk("rst_mem_stb", mem_stb_o, 1'b0);
      chk("rst_mem_sel", mem_sel_rom_ram_o, 1'b0);
      chk("rst_mem_adr", mem_adr_o, 22'h0);
      chk("rst_mem_be", mem_be_o, 4'h0);
      chk("rst_acks", {ibus_ack_o, ibus_err_o, dbus_ack_o, dbus_err_o}, 4'h0);
      tick(); tick();
      rst_in = 1'b1;

      // 1: ibus fetch from ROM, slow adapter
      tick();
      lat = 20; rsp_dat = 32'hDEAD_BEEF;
      ibus_stb_i = 1'b1; ibus_adr_i = 32'h0000_0010;
      sb_q.push_back(mk(1'b0, 22'h4, 1'b0, 4'hF, 32'h0, 1'b0));
      wait_ack(0, 100, n);
      chk("t1_ack", ibus_ack_o, 1'b1);
      chk("t1_ack_cycle", n, 21);
      chk("t1_dat", ibus_dat_o, 32'hDEAD_BEEF);
      chk("t1_err", ibus_err_o, 1'b0);
      chk("t1_dbus_ack", dbus_ack_o, 1'b0);
      tick();
      ibus_stb_i = 1'b0;
      @(negedge clk_i);
      chk("t1_stb_after", mem_stb_o, 1'b0);
      chk("t1_ack_after", ibus_ack_o, 1'b0);

      // 2: dbus byte store to RAM
      tick();
      lat = 5;
      dbus_stb_i = 1'b1; dbus_we_i = 1'b1; dbus_be_i = 4'b1000;
      dbus_adr_i = 32'h0100_0003; dbus_dat_i = 32'hAB00_0000;
      sb_q.push_back(mk(1'b1, 22'h0, 1'b1, 4'b1000, 32'hAB00_0000, 1'b1));
      wait_ack(1, 50, n);
      chk("t2_ack", dbus_ack_o, 1'b1);
      chk("t2_ack_cycle", n, 6);
      chk("t2_err", dbus_err_o, 1'b0);
      chk("t2_ibus_ack", ibus_ack_o, 1'b0);
      tick();
      dbus_stb_i = 1'b0; dbus_we_i = 1'b0;

      // 3: contention, round robin (last grant was dbus, so ibus goes first)
      tick();
      lat = 2; rsp_dat = 32'h1111_2222;
      ibus_stb_i = 1'b1; ibus_adr_i = 32'h0000_0020;
      dbus_stb_i = 1'b1; dbus_we_i = 1'b0; dbus_be_i = 4'hF; dbus_adr_i = 32'h0100_0040;
      for (int k = 0; k < 4; k++)
         sb_q.push_back((k % 2 == 0) ? mk(1'b0, 22'h8, 1'b0, 4'hF, 32'h0, 1'b0)
                                     : mk(1'b1, 22'h10, 1'b0, 4'hF, 32'h0, 1'b0));
      for (int k = 0; k < 4; k++) begin
         wait_ack(2, 20, n);
         chk("t3_rr_ibus_ack", ibus_ack_o, (k % 2 == 0));
         chk("t3_rr_dbus_ack", dbus_ack_o, (k % 2 == 1));
         if (k < 3) @(negedge clk_i);
      end
      tick();
      ibus_stb_i = 1'b0; dbus_stb_i = 1'b0;

      // 3b: contention, fixed priority instance
      tick();
      fp_ibus_stb = 1'b1; fp_dbus_stb = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_ack(3, 20, n);
         chk("t3_fp_dbus_ack", fp_dbus_ack, 1'b1);
         chk("t3_fp_ibus_ack", fp_ibus_ack, 1'b0);
         if (k == 0) begin
            chk("t3_fp_sel", fp_mem_sel, 1'b1);
            chk("t3_fp_adr", fp_mem_adr, 22'h10);
            chk("t3_fp_we_be", {fp_mem_we, fp_mem_be}, 5'b0_1111);
            chk("t3_fp_dat", fp_dbus_dat, 32'h5A5A_0001);
            chk("t3_fp_err", fp_dbus_err, 1'b0);
         end
         if (k < 2) @(negedge clk_i);
      end
      tick();
      fp_dbus_stb = 1'b0;
      wait_ack(3, 20, n);
      chk("t3_fp_ibus_served", fp_ibus_ack, 1'b1);
      chk("t3_fp_ibus_dat", fp_ibus_dat, 32'h5A5A_0001);
      chk("t3_fp_ibus_err", fp_ibus_err, 1'b0);
      tick();
      fp_ibus_stb = 1'b0;

      // 4: dbus write to ROM and ibus read of unmapped space
      tick();
      dbus_stb_i = 1'b1; dbus_we_i = 1'b1; dbus_be_i = 4'hF;
      dbus_adr_i = 32'h0000_0100; dbus_dat_i = 32'h1234_5678;
      @(negedge clk_i);
      chk("t4_req_cycle_ack", dbus_ack_o, 1'b0);
      @(negedge clk_i);
      chk("t4_ack_err", {dbus_ack_o, dbus_err_o}, 2'b11);
      chk("t4_dat", dbus_dat_o, 32'h0);
      chk("t4_no_stb", mem_stb_o, 1'b0);
      tick();
      dbus_stb_i = 1'b0; dbus_we_i = 1'b0;
      @(negedge clk_i);
      chk("t4_one_cycle", {dbus_ack_o, dbus_err_o}, 2'b00);
      chk("t4_no_stb_after", mem_stb_o, 1'b0);
      tick();
      ibus_stb_i = 1'b1; ibus_adr_i = 32'h0200_0000;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t4i_ack_err", {ibus_ack_o, ibus_err_o}, 2'b11);
      chk("t4i_dat", ibus_dat_o, 32'h0);
      chk("t4i_no_stb", mem_stb_o, 1'b0);
      tick();
      ibus_stb_i = 1'b0;
      @(negedge clk_i);
      chk("t4i_one_cycle", {ibus_ack_o, ibus_err_o}, 2'b00);

      // 6: back-to-back fetches
      tick();
      lat = 3; rsp_dat = 32'h0BAD_F00D;
      ibus_stb_i = 1'b1; ibus_adr_i = 32'h0000_0100;
      sb_q.push_back(mk(1'b0, 22'h40, 1'b0, 4'hF, 32'h0, 1'b0));
      wait_ack(0, 20, n);
      chk("t6_ack1", ibus_ack_o, 1'b1);
      tick();
      ibus_adr_i = 32'h0000_0104;
      sb_q.push_back(mk(1'b0, 22'h41, 1'b0, 4'hF, 32'h0, 1'b0));
      @(negedge clk_i);
      chk("t6_gap", mem_stb_o, 1'b0);
      @(negedge clk_i);
      chk("t6_regrant", mem_stb_o, 1'b1);
      chk("t6_adr2", mem_adr_o, 22'h41);
      wait_ack(0, 20, n);
      chk("t6_ack2", ibus_ack_o, 1'b1);
      chk("t6_dat2", ibus_dat_o, 32'h0BAD_F00D);
      tick();
      ibus_stb_i = 1'b0;

      // 5: asynchronous reset in BUSY_D
      tick();
      lat = 50;
      dbus_stb_i = 1'b1; dbus_we_i = 1'b0; dbus_be_i = 4'hF; dbus_adr_i = 32'h0100_0200;
      sb_q.push_back(mk(1'b1, 22'h80, 1'b0, 4'hF, 32'h0, 1'b0));
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t5_busy_stb", mem_stb_o, 1'b1);
      #2 rst_in = 1'b0;
      #1;
      chk("t5_async_stb", mem_stb_o, 1'b0);
      chk("t5_async_sel", mem_sel_rom_ram_o, 1'b0);
      chk("t5_async_acks", {ibus_ack_o, dbus_ack_o}, 2'b00);
      dbus_stb_i = 1'b0;
      tick(); tick();
      rst_in = 1'b1;
      tick();
      lat = 2; rsp_dat = 32'hCAFE_0005;
      ibus_stb_i = 1'b1; ibus_adr_i = 32'h0100_0008;
      sb_q.push_back(mk(1'b1, 22'h2, 1'b0, 4'hF, 32'h0, 1'b0));
      wait_ack(0, 20, n);
      chk("t5_post_ack", ibus_ack_o, 1'b1);
      chk("t5_post_cycle", n, 3);
      chk("t5_post_dat", ibus_dat_o, 32'hCAFE_0005);
      tick();
      ibus_stb_i = 1'b0;
      tick(); tick();

      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
